// File: rtl/pet_memmap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pet_memmap_ctrl                                                   |
// | Brief  : PET address decode and read mux, 8096-style banked expansion RAM, |
// |          and an idle-cycle DMA port on the shared single-port RAM.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pet_memmap_ctrl #(
    parameter int          RAM_KB    = 32,
    parameter bit          EXP_EN    = 1'b1,
    parameter logic [15:0] CTRL_ADDR = 16'hFFF0,
    parameter logic [7:0]  OPEN_BUS  = 8'h55
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1m,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    output logic [7:0]  cpu_dout,
    input  logic [7:0]  rom_rdata,
    input  logic [7:0]  vram_rdata,
    input  logic [7:0]  io_rdata,
    input  logic [7:0]  ram_rdata,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        vram_we,
    output logic        io_we,
    input  logic        dma_req,
    input  logic [16:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout,
    output logic        dma_ack,
    output logic        dma_busy,
    output logic [7:0]  map_ctrl
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_PEND    = 2'd1;
    localparam logic [1:0]  S_CAPT    = 2'd2;
    localparam logic [16:0] c_RAM_TOP = 17'(RAM_KB * 1024);

    logic [1:0]  r_state;
    logic [7:0]  r_ctrl;
    logic [16:0] r_dma_addr;
    logic [7:0]  r_dma_din;
    logic        r_dma_we;
    logic [7:0]  r_dma_dout;
    logic        r_dma_ack;

    logic        w_cpu_wr;
    logic        w_ctrl_hit;
    logic        w_exp_on;
    logic        w_scr_peek;
    logic        w_io_rng;
    logic        w_io_peek;
    logic        w_exp_sel;
    logic        w_base_sel;
    logic        w_norm_hi;
    logic        w_vram_rng;
    logic        w_rom_rng;
    logic        w_exp_lo;
    logic        w_exp_wp;
    logic        w_wr_ok;
    logic        w_cpu_ram_we;
    logic        w_grant;
    logic [16:0] w_cpu_phys;

    assign w_cpu_wr   = cpu_we & ce_1m;
    assign w_ctrl_hit = EXP_EN && (cpu_addr == CTRL_ADDR);
    assign w_exp_on   = EXP_EN && r_ctrl[7];
    assign w_io_rng   = (cpu_addr[15:11] == 5'b11101);
    assign w_vram_rng = (cpu_addr[15:11] == 5'b10000);
    assign w_rom_rng  = (cpu_addr[15:13] == 3'b110) || (cpu_addr[15:11] == 5'b11100) ||
                        (cpu_addr[15:12] == 4'hF);
    assign w_scr_peek = r_ctrl[5] && (cpu_addr[15:12] == 4'h8);
    assign w_io_peek  = r_ctrl[6] && w_io_rng;
    assign w_exp_sel  = w_exp_on && cpu_addr[15] && !w_scr_peek && !w_io_peek;
    assign w_base_sel = !cpu_addr[15] && ({1'b0, cpu_addr} < c_RAM_TOP);
    assign w_norm_hi  = cpu_addr[15] && !w_exp_sel;
    assign w_exp_lo   = !cpu_addr[14];
    assign w_exp_wp   = w_exp_lo ? r_ctrl[0] : r_ctrl[1];

    // Expansion banks: $8000 window -> 17'h08000/0C000, $C000 window -> 17'h10000/14000
    always_comb begin
        w_cpu_phys = {2'b00, cpu_addr[14:0]};
        if (w_exp_sel) begin
            w_cpu_phys = w_exp_lo ? {2'b01, r_ctrl[2], cpu_addr[13:0]}
                                  : {2'b10, r_ctrl[3], cpu_addr[13:0]};
        end
    end

    // A control-register write is consumed entirely by the register
    assign w_wr_ok      = w_cpu_wr && !w_ctrl_hit;
    assign w_cpu_ram_we = w_wr_ok && (w_base_sel || (w_exp_sel && !w_exp_wp));
    assign vram_we      = w_wr_ok && w_norm_hi && w_vram_rng;
    assign io_we        = w_wr_ok && w_norm_hi && w_io_rng;

    assign w_grant  = (r_state == S_PEND) && !ce_1m;
    assign ram_addr = w_grant ? r_dma_addr : w_cpu_phys;
    assign ram_din  = w_grant ? r_dma_din  : cpu_din;
    assign ram_we   = w_grant ? r_dma_we   : w_cpu_ram_we;

    always_comb begin
        cpu_dout = OPEN_BUS;
        if (w_base_sel || w_exp_sel) begin
            cpu_dout = ram_rdata;
        end else if (w_norm_hi) begin
            if (w_vram_rng)     cpu_dout = vram_rdata;
            else if (w_io_rng)  cpu_dout = io_rdata;
            else if (w_rom_rng) cpu_dout = rom_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 8'h00;
            r_dma_addr <= 17'd0;
            r_dma_din  <= 8'h00;
            r_dma_we   <= 1'b0;
            r_dma_dout <= 8'h00;
            r_dma_ack  <= 1'b0;
        end else begin
            r_dma_ack <= 1'b0;
            if (w_cpu_wr && w_ctrl_hit) r_ctrl <= cpu_din;
            case (r_state)
                S_IDLE: begin
                    if (dma_req) begin
                        r_dma_addr <= dma_addr;
                        r_dma_din  <= dma_din;
                        r_dma_we   <= dma_we;
                        r_state    <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!ce_1m) r_state <= S_CAPT;
                end
                S_CAPT: begin
                    // ram_rdata now holds the word addressed in the grant cycle
                    if (!r_dma_we) r_dma_dout <= ram_rdata;
                    r_dma_ack <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dma_dout = r_dma_dout;
    assign dma_ack  = r_dma_ack;
    assign dma_busy = (r_state != S_IDLE);
    assign map_ctrl = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_pet_memmap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pet_memmap_ctrl                                                |
// | Brief  : Self-checking bench for pet_memmap_ctrl (RAM_KB=16, EXP_EN=1).    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_pet_memmap_ctrl;

    localparam int c_RAM_KB   = 16;
    localparam int c_SRC_RAM  = 0;
    localparam int c_SRC_VR   = 1;
    localparam int c_SRC_ROM  = 2;
    localparam int c_SRC_IO   = 3;
    localparam int c_SRC_OPEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_1m;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  cpu_dout;
    logic [7:0]  rom_rdata, vram_rdata, io_rdata;
    logic [7:0]  ram_rdata;
    logic [16:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we, vram_we, io_we;
    logic        dma_req;
    logic [16:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_din;
    logic [7:0]  dma_dout;
    logic        dma_ack, dma_busy;
    logic [7:0]  map_ctrl;

    int errors = 0;
    int checks = 0;
    logic [7:0] cur_ctrl;
    logic [7:0] exp_dma_dout;
    logic [7:0] shadow [int];

    pet_memmap_ctrl #(.RAM_KB(c_RAM_KB), .EXP_EN(1'b1), .CTRL_ADDR(16'hFFF0), .OPEN_BUS(8'h55)) dut (
        .clk(clk), .reset(reset), .ce_1m(ce_1m), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_we(cpu_we), .cpu_dout(cpu_dout), .rom_rdata(rom_rdata), .vram_rdata(vram_rdata),
        .io_rdata(io_rdata), .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .vram_we(vram_we), .io_we(io_we), .dma_req(dma_req),
        .dma_addr(dma_addr), .dma_we(dma_we), .dma_din(dma_din), .dma_dout(dma_dout),
        .dma_ack(dma_ack), .dma_busy(dma_busy), .map_ctrl(map_ctrl)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM; unwritten locations read a fixed address pattern
    function automatic logic [7:0] pat(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
    endfunction

    logic [7:0] mem     [0:131071];
    bit         written [0:131071];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_din;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= written[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    function automatic logic [7:0] exp_rd(input logic [16:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference decode, written straight from the address-map rules
    typedef struct {
        int          src;
        logic [16:0] phys;
        bit          rwe;
        bit          vwe;
        bit          iwe;
    } dec_t;

    function automatic dec_t model(input logic [15:0] a, input bit we, input bit ce,
                                   input logic [7:0] c);
        dec_t r;
        int   ai = int'(a);
        bit   wr = we && ce && (a != 16'hFFF0);
        bit   exp_map;
        r.src = c_SRC_OPEN; r.phys = '0; r.rwe = 0; r.vwe = 0; r.iwe = 0;
        if (ai < 32768) begin
            if (ai < c_RAM_KB * 1024) begin
                r.src = c_SRC_RAM; r.phys = 17'(ai); r.rwe = wr;
            end
        end else begin
            exp_map = c[7] && !(c[5] && ai < 'h9000) && !(c[6] && ai >= 'hE800 && ai < 'hF000);
            if (exp_map) begin
                r.src = c_SRC_RAM;
                if (ai < 'hC000) begin
                    r.phys = 17'('h8000 + (c[2] ? 'h4000 : 0) + ai % 'h4000);
                    r.rwe  = wr && !c[0];
                end else begin
                    r.phys = 17'('h10000 + (c[3] ? 'h4000 : 0) + ai % 'h4000);
                    r.rwe  = wr && !c[1];
                end
            end else if (ai < 'h8800) begin
                r.src = c_SRC_VR; r.vwe = wr;
            end else if (ai >= 'hE800 && ai < 'hF000) begin
                r.src = c_SRC_IO; r.iwe = wr;
            end else if (ai >= 'hC000) begin
                r.src = c_SRC_ROM;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] src_val(input int src);
        case (src)
            c_SRC_RAM: return ram_rdata;
            c_SRC_VR:  return vram_rdata;
            c_SRC_ROM: return rom_rdata;
            c_SRC_IO:  return io_rdata;
            default:   return 8'h55;
        endcase
    endfunction

    task automatic check_dec(input string tag, input dec_t e);
        chk({tag, ".cpu_dout"}, 32'(cpu_dout), 32'(src_val(e.src)));
        chk({tag, ".ram_we"},   32'(ram_we),   32'(e.rwe));
        chk({tag, ".vram_we"},  32'(vram_we),  32'(e.vwe));
        chk({tag, ".io_we"},    32'(io_we),    32'(e.iwe));
        if (e.src == c_SRC_RAM) begin
            chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(e.phys));
            chk({tag, ".ram_din"},  32'(ram_din),  32'(cpu_din));
        end
    endtask

    task automatic set_ctrl(input logic [7:0] v);
        cpu_addr = 16'hFFF0; cpu_din = v; cpu_we = 1'b1; ce_1m = 1'b1;
        @(posedge clk); #1;
        cpu_we   = 1'b0;
        cur_ctrl = v;
        chk("map_ctrl_load", 32'(map_ctrl), 32'(v));
    endtask

    // Issue one DMA with a per-cycle ce_1m pattern (random unless forced low)
    task automatic run_dma(input string tag, input logic [16:0] a, input bit we,
                           input logic [7:0] d, input bit force_ce0);
        int g = -1;
        bit got_ack = 0;
        logic [7:0] rd = exp_rd(a);
        dma_req = 1'b1; dma_addr = a; dma_we = we; dma_din = d;
        ce_1m = force_ce0 ? 1'b0 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        dma_req = 1'b0;
        for (int cyc = 0; cyc < 40 && !got_ack; cyc++) begin
            ce_1m = (force_ce0 || cyc > 30) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (g < 0 && !ce_1m) begin
                g = cyc;
                chk({tag, ".grant_addr"}, 32'(ram_addr), 32'(a));
                chk({tag, ".grant_we"},   32'(ram_we),   32'(we));
            end
            @(posedge clk); #1;
            if (g >= 0 && cyc == g + 1) begin
                got_ack = 1;
                chk({tag, ".ack"}, 32'(dma_ack), 32'd1);
                if (!we) exp_dma_dout = rd;
                chk({tag, ".dout"}, 32'(dma_dout), 32'(exp_dma_dout));
            end else begin
                chk({tag, ".no_early_ack"}, 32'(dma_ack), 32'd0);
            end
        end
        if (!got_ack) chk({tag, ".timeout"}, 32'd0, 32'd1);
        if (we) shadow[int'(a)] = d;
        ce_1m = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  ctrl;
        logic [15:0] addr;
        bit          we;
        bit          ce;
        int          src;
        logic [16:0] phys;
        bit          rwe;
        bit          vwe;
        bit          iwe;
    } vec_t;

    vec_t tbl [25];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h00, 16'h8000, 0, 1, c_SRC_VR,   17'h00000, 0, 0, 0};
        tbl[1]  = '{8'h00, 16'hE810, 0, 1, c_SRC_IO,   17'h00000, 0, 0, 0};
        tbl[2]  = '{8'h00, 16'h5000, 0, 1, c_SRC_OPEN, 17'h00000, 0, 0, 0};
        tbl[3]  = '{8'h00, 16'h1234, 1, 1, c_SRC_RAM,  17'h01234, 1, 0, 0};
        tbl[4]  = '{8'h00, 16'h5000, 1, 1, c_SRC_OPEN, 17'h00000, 0, 0, 0};
        tbl[5]  = '{8'h00, 16'h8000, 1, 0, c_SRC_VR,   17'h00000, 0, 0, 0};
        tbl[6]  = '{8'h00, 16'h87FF, 1, 1, c_SRC_VR,   17'h00000, 0, 1, 0};
        tbl[7]  = '{8'h00, 16'hE810, 1, 1, c_SRC_IO,   17'h00000, 0, 0, 1};
        tbl[8]  = '{8'h00, 16'hC000, 0, 1, c_SRC_ROM,  17'h00000, 0, 0, 0};
        tbl[9]  = '{8'h00, 16'hF800, 0, 1, c_SRC_ROM,  17'h00000, 0, 0, 0};
        tbl[10] = '{8'h00, 16'h9000, 0, 1, c_SRC_OPEN, 17'h00000, 0, 0, 0};
        tbl[11] = '{8'h80, 16'h9000, 1, 1, c_SRC_RAM,  17'h09000, 1, 0, 0};
        tbl[12] = '{8'h8C, 16'hC123, 1, 1, c_SRC_RAM,  17'h14123, 1, 0, 0};
        tbl[13] = '{8'h8E, 16'hC123, 1, 1, c_SRC_RAM,  17'h14123, 0, 0, 0};
        tbl[14] = '{8'hE0, 16'h8400, 0, 1, c_SRC_VR,   17'h00000, 0, 0, 0};
        tbl[15] = '{8'hE0, 16'hE810, 0, 1, c_SRC_IO,   17'h00000, 0, 0, 0};
        tbl[16] = '{8'hE0, 16'h9000, 1, 1, c_SRC_RAM,  17'h09000, 1, 0, 0};
        tbl[17] = '{8'hE0, 16'h8400, 1, 1, c_SRC_VR,   17'h00000, 0, 1, 0};
        tbl[18] = '{8'h80, 16'hFFF0, 1, 1, c_SRC_RAM,  17'h13FF0, 0, 0, 0};
        tbl[19] = '{8'h84, 16'h8123, 0, 1, c_SRC_RAM,  17'h0C123, 0, 0, 0};
        tbl[20] = '{8'h81, 16'hA000, 1, 1, c_SRC_RAM,  17'h0A000, 0, 0, 0};
        tbl[21] = '{8'hC0, 16'hE900, 1, 1, c_SRC_IO,   17'h00000, 0, 0, 1};
        tbl[22] = '{8'h00, 16'h3FFF, 1, 1, c_SRC_RAM,  17'h03FFF, 1, 0, 0};
        tbl[23] = '{8'h00, 16'h4000, 1, 1, c_SRC_OPEN, 17'h00000, 0, 0, 0};
        tbl[24] = '{8'h00, 16'hFFF0, 1, 1, c_SRC_ROM,  17'h00000, 0, 0, 0};

        reset = 1'b1; ce_1m = 1'b1; cpu_addr = 16'h1000; cpu_din = 8'h00; cpu_we = 1'b0;
        rom_rdata = 8'hA1; vram_rdata = 8'hB2; io_rdata = 8'hC3;
        dma_req = 1'b0; dma_addr = '0; dma_we = 1'b0; dma_din = 8'h00;
        cur_ctrl = 8'h00; exp_dma_dout = 8'h00;
        #1;
        chk("rst.map_ctrl", 32'(map_ctrl), 32'd0);
        chk("rst.dma_ack",  32'(dma_ack),  32'd0);
        chk("rst.dma_busy", 32'(dma_busy), 32'd0);
        chk("rst.dma_dout", 32'(dma_dout), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // DMA read with ce_1m = 1,1,0,1: access only in the ce_1m=0 cycle, one ack
        dma_req = 1'b1; dma_addr = 17'h1ABCD; dma_we = 1'b0;
        @(posedge clk); #1;
        dma_req = 1'b0;
        chk("dma_seq.busy", 32'(dma_busy), 32'd1);
        chk("dma_seq.cpu_owns_addr", 32'(ram_addr), 32'h01000);
        @(posedge clk); #1;
        chk("dma_seq.cpu_owns_addr2", 32'(ram_addr), 32'h01000);
        ce_1m = 1'b0; #1;
        chk("dma_seq.grant_addr", 32'(ram_addr), 32'h1ABCD);
        chk("dma_seq.grant_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        ce_1m = 1'b1;
        chk("dma_seq.ack_not_yet", 32'(dma_ack), 32'd0);
        @(posedge clk); #1;
        chk("dma_seq.ack", 32'(dma_ack), 32'd1);
        exp_dma_dout = exp_rd(17'h1ABCD);
        chk("dma_seq.dout", 32'(dma_dout), 32'(exp_dma_dout));
        @(posedge clk); #1;
        chk("dma_seq.ack_once", 32'(dma_ack), 32'd0);
        chk("dma_seq.idle", 32'(dma_busy), 32'd0);

        // Minimum latency: request driven after edge 0, ack after edge 3
        begin
            int n = 0;
            dma_req = 1'b1; dma_addr = 17'h00ABC; dma_we = 1'b1; dma_din = 8'h9E; ce_1m = 1'b0;
            for (int i = 1; i <= 10 && n == 0; i++) begin
                @(posedge clk); #1;
                dma_req = 1'b0;
                if (dma_ack) n = i;
            end
            chk("dma_minlat.edges", 32'(n), 32'd3);
            chk("dma_write.dout_kept", 32'(dma_dout), 32'(exp_dma_dout));
            shadow[int'(17'h00ABC)] = 8'h9E;
            ce_1m = 1'b1;
        end
        run_dma("dma_rb", 17'h00ABC, 1'b0, 8'h00, 1'b1);

        for (int t = 0; t < 20; t++) begin
            logic [16:0] a;
            a = (t % 4 == 3) ? 17'h00ABC : 17'($urandom);
            run_dma($sformatf("dma_rand%0d", t), a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end

        // Reset during PEND aborts without ack and clears the control register
        set_ctrl(8'h8C);
        cpu_addr = 16'h1000; ce_1m = 1'b1;
        dma_req = 1'b1; dma_addr = 17'h00777; dma_we = 1'b0;
        @(posedge clk); #1;
        dma_req = 1'b0;
        chk("rst_mid.busy_before", 32'(dma_busy), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1; #1;
        chk("rst_mid.busy", 32'(dma_busy), 32'd0);
        chk("rst_mid.ack", 32'(dma_ack), 32'd0);
        chk("rst_mid.map_ctrl", 32'(map_ctrl), 32'd0);
        chk("rst_mid.dout", 32'(dma_dout), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; cur_ctrl = 8'h00; exp_dma_dout = 8'h00; ce_1m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_mid.no_stale_ack", 32'(dma_ack), 32'd0);
        end
        run_dma("rst_mid.new_req", 17'h00777, 1'b0, 8'h00, 1'b1);

        // Table-driven address map vectors
        for (int i = 0; i < 25; i++) begin
            dec_t e;
            set_ctrl(tbl[i].ctrl);
            cpu_addr = tbl[i].addr; cpu_we = tbl[i].we; ce_1m = tbl[i].ce; cpu_din = 8'h11;
            #1;
            e.src = tbl[i].src; e.phys = tbl[i].phys;
            e.rwe = tbl[i].rwe; e.vwe = tbl[i].vwe; e.iwe = tbl[i].iwe;
            check_dec($sformatf("tbl%0d", i), e);
            @(posedge clk); #1;
            cpu_we = 1'b0; ce_1m = 1'b1;
        end

        // Randomized CPU traffic against the reference decode
        begin
            logic [15:0] corners [10];
            corners = '{16'hFFF0, 16'h8FFF, 16'h9000, 16'hE800, 16'hEFFF,
                        16'hBFFF, 16'hC000, 16'h3FFF, 16'h4000, 16'h7FFF};
            for (int it = 0; it < 400; it++) begin
                if (it % 16 == 0) set_ctrl(8'($urandom));
                cpu_addr   = (it % 5 == 0) ? corners[$urandom_range(0, 9)] : 16'($urandom);
                cpu_we     = 1'($urandom_range(0, 1));
                ce_1m      = 1'($urandom_range(0, 1));
                cpu_din    = 8'($urandom);
                rom_rdata  = 8'($urandom);
                vram_rdata = 8'($urandom);
                io_rdata   = 8'($urandom);
                #1;
                check_dec($sformatf("rnd%0d", it), model(cpu_addr, cpu_we, ce_1m, cur_ctrl));
                @(posedge clk); #1;
                if (cpu_we && ce_1m && cpu_addr == 16'hFFF0) cur_ctrl = cpu_din;
                chk("rnd.map_ctrl", 32'(map_ctrl), 32'(cur_ctrl));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
